// File: rtl/password_entry_fsm.sv
// Password lock controller: collects BCD digits from keypad edge pulses, checks them against
// a stored password, and handles unlock/relock, failed-attempt lockout and password change.
module password_entry_fsm #(
    parameter int unsigned PW_LEN        = 4,
    parameter logic [15:0] DEFAULT_PW    = 16'h1234,
    parameter int unsigned MAX_FAIL      = 3,
    parameter int unsigned LOCK_CYCLES   = 500,
    parameter int unsigned UNLOCK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  digit_pos,
    input  logic        enter_pos,
    input  logic        clear_pos,
    input  logic        set_pos,
    output logic        unlocked,
    output logic        alarm,
    output logic        setting,
    output logic [2:0]  entry_cnt,
    output logic [1:0]  fail_cnt,
    output logic [15:0] entry_buf
);

    typedef enum logic [1:0] {
        StLocked,
        StUnlocked,
        StSet,
        StLockout
    } state_e;

    // Exactly one pulse is acted on per cycle; the others are dropped.
    typedef enum logic [2:0] {
        KeyNone,
        KeyClear,
        KeyEnter,
        KeySet,
        KeyDigit
    } key_e;

    localparam logic [15:0] BufMask    = 16'((32'd1 << (4 * PW_LEN)) - 32'd1);
    localparam logic [2:0]  PwLenCnt   = 3'(PW_LEN);
    localparam logic [1:0]  MaxFail    = 2'(MAX_FAIL);
    localparam logic [31:0] UnlockLast = 32'(UNLOCK_CYCLES - 1);
    localparam logic [31:0] LockLast   = 32'(LOCK_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] pw_q, pw_d;
    logic [15:0] buf_q, buf_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  fail_q, fail_d;
    logic [31:0] timer_q, timer_d;
    logic        unlocked_q, alarm_q, setting_q;

    logic        digit_valid;
    logic [3:0]  digit_code;
    key_e        key;
    logic        entry_full;
    logic        entry_match;

    always_comb begin
        digit_code = '0;
        for (int i = 0; i < 10; i++) begin
            if (digit_pos[i]) begin
                digit_code = 4'(i);
            end
        end
    end

    assign digit_valid = $onehot(digit_pos);
    assign entry_full  = (cnt_q == PwLenCnt);
    assign entry_match = entry_full && (buf_q == pw_q);

    always_comb begin
        key = KeyNone;
        if (clear_pos) begin
            key = KeyClear;
        end else if (enter_pos) begin
            key = KeyEnter;
        end else if (set_pos) begin
            key = KeySet;
        end else if (digit_valid) begin
            key = KeyDigit;
        end
    end

    always_comb begin
        state_d = state_q;
        pw_d    = pw_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        timer_d = timer_q;

        unique case (state_q)
            StLocked: begin
                timer_d = '0;
                case (key)
                    KeyClear: begin
                        buf_d = '0;
                        cnt_d = '0;
                    end
                    KeyEnter: begin
                        if (entry_match) begin
                            state_d = StUnlocked;
                            fail_d  = '0;
                        end else begin
                            fail_d = fail_q + 2'd1;
                            if (fail_q + 2'd1 == MaxFail) begin
                                state_d = StLockout;
                            end
                        end
                        buf_d = '0;
                        cnt_d = '0;
                    end
                    KeyDigit: begin
                        if (!entry_full) begin
                            buf_d = {buf_q[11:0], digit_code} & BufMask;
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end

            StUnlocked: begin
                timer_d = timer_q + 32'd1;
                if (timer_q == UnlockLast || key == KeyEnter) begin
                    state_d = StLocked;
                    timer_d = '0;
                end else if (key == KeySet) begin
                    // Timer is held across SET; every exit from SET restarts or drops it.
                    state_d = StSet;
                    timer_d = timer_q;
                    buf_d   = '0;
                    cnt_d   = '0;
                end
            end

            StSet: begin
                case (key)
                    KeyClear: begin
                        buf_d = '0;
                        cnt_d = '0;
                    end
                    KeyEnter: begin
                        if (entry_full) begin
                            pw_d    = buf_q;
                            state_d = StLocked;
                        end else begin
                            state_d = StUnlocked;
                        end
                        timer_d = '0;
                        buf_d   = '0;
                        cnt_d   = '0;
                    end
                    KeyDigit: begin
                        if (!entry_full) begin
                            buf_d = {buf_q[11:0], digit_code} & BufMask;
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end

            StLockout: begin
                timer_d = timer_q + 32'd1;
                if (timer_q == LockLast) begin
                    state_d = StLocked;
                    timer_d = '0;
                    fail_d  = '0;
                    buf_d   = '0;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = StLocked;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StLocked;
            pw_q       <= DEFAULT_PW & BufMask;
            buf_q      <= '0;
            cnt_q      <= '0;
            fail_q     <= '0;
            timer_q    <= '0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
            setting_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pw_q       <= pw_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            timer_q    <= timer_d;
            unlocked_q <= (state_d == StUnlocked) || (state_d == StSet);
            alarm_q    <= (state_d == StLockout);
            setting_q  <= (state_d == StSet);
        end
    end

    assign unlocked  = unlocked_q;
    assign alarm     = alarm_q;
    assign setting   = setting_q;
    assign entry_cnt = cnt_q;
    assign fail_cnt  = fail_q;
    assign entry_buf = buf_q;

endmodule

// File: tb/tb_password_entry_fsm.sv
// Bench for password_entry_fsm: directed scenarios plus random key traffic, all checked
// cycle by cycle against a digit-queue / deadline model of the lock.
module tb_password_entry_fsm;

    localparam int unsigned PW_LEN        = 4;
    localparam logic [15:0] DEFAULT_PW    = 16'h1234;
    localparam int unsigned MAX_FAIL      = 3;
    localparam int unsigned LOCK_CYCLES   = 20;
    localparam int unsigned UNLOCK_CYCLES = 30;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  digit_pos;
    logic        enter_pos, clear_pos, set_pos;
    logic        unlocked, alarm, setting;
    logic [2:0]  entry_cnt;
    logic [1:0]  fail_cnt;
    logic [15:0] entry_buf;

    always #5 clk = ~clk;

    password_entry_fsm #(
        .PW_LEN       (PW_LEN),
        .DEFAULT_PW   (DEFAULT_PW),
        .MAX_FAIL     (MAX_FAIL),
        .LOCK_CYCLES  (LOCK_CYCLES),
        .UNLOCK_CYCLES(UNLOCK_CYCLES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .digit_pos(digit_pos),
        .enter_pos(enter_pos),
        .clear_pos(clear_pos),
        .set_pos  (set_pos),
        .unlocked (unlocked),
        .alarm    (alarm),
        .setting  (setting),
        .entry_cnt(entry_cnt),
        .fail_cnt (fail_cnt),
        .entry_buf(entry_buf)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: entered digits and password as digit queues; timers as absolute edge deadlines.
    int     m_buf[$];
    int     m_pw[$];
    int     m_fails;
    bit     m_open, m_setting, m_alarm;
    longint m_edge     = 0;
    longint m_deadline = 0;

    function automatic void model_reset();
        logic [15:0] dp;
        dp = DEFAULT_PW;
        m_buf.delete();
        m_pw.delete();
        for (int i = int'(PW_LEN) - 1; i >= 0; i--) m_pw.push_back(int'((dp >> (4 * i)) & 16'hF));
        m_fails   = 0;
        m_open    = 0;
        m_setting = 0;
        m_alarm   = 0;
    endfunction

    function automatic bit model_match();
        if (m_buf.size() != int'(PW_LEN)) return 0;
        for (int i = 0; i < int'(PW_LEN); i++) if (m_buf[i] != m_pw[i]) return 0;
        return 1;
    endfunction

    function automatic int model_buf_value();
        int v = 0;
        foreach (m_buf[i]) v = v * 16 + m_buf[i];
        return v;
    endfunction

    function automatic void model_step(input bit rn, input logic [9:0] d, input bit e,
                                       input bit c, input bit s);
        int key;   // 0 none, 1 clear, 2 enter, 3 set, 4 digit
        int code = 0;
        m_edge++;
        if (!rn) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 10; i++) if (d[i]) code = i;
        key = c ? 1 : e ? 2 : s ? 3 : ($countones(d) == 1) ? 4 : 0;
        if (m_alarm) begin
            if (m_edge == m_deadline) begin
                m_alarm = 0;
                m_fails = 0;
                m_buf.delete();
            end
            return;
        end
        if (m_open && !m_setting) begin
            if (m_edge == m_deadline || key == 2) begin
                m_open = 0;
            end else if (key == 3) begin
                m_setting = 1;
                m_buf.delete();
            end
            return;
        end
        if (key == 1) begin
            m_buf.delete();
        end else if (key == 2) begin
            if (m_setting) begin
                m_setting = 0;
                if (m_buf.size() == int'(PW_LEN)) begin
                    m_pw   = m_buf;
                    m_open = 0;
                end else begin
                    m_deadline = m_edge + UNLOCK_CYCLES;
                end
            end else if (model_match()) begin
                m_open     = 1;
                m_fails    = 0;
                m_deadline = m_edge + UNLOCK_CYCLES;
            end else begin
                m_fails++;
                if (m_fails == int'(MAX_FAIL)) begin
                    m_alarm    = 1;
                    m_deadline = m_edge + LOCK_CYCLES;
                end
            end
            m_buf.delete();
        end else if (key == 4 && m_buf.size() < int'(PW_LEN)) begin
            m_buf.push_back(code);
        end
    endfunction

    task automatic compare_all();
        check_eq("unlocked", 32'(unlocked), 32'(m_open));
        check_eq("alarm", 32'(alarm), 32'(m_alarm));
        check_eq("setting", 32'(setting), 32'(m_setting));
        check_eq("entry_cnt", 32'(entry_cnt), 32'(m_buf.size()));
        check_eq("fail_cnt", 32'(fail_cnt), 32'(m_fails));
        check_eq("entry_buf", 32'(entry_buf), 32'(model_buf_value()));
    endtask

    task automatic tick(input bit rn, input logic [9:0] d, input bit e, input bit c,
                        input bit s);
        rst_n     = rn;
        digit_pos = d;
        enter_pos = e;
        clear_pos = c;
        set_pos   = s;
        @(posedge clk);
        model_step(rn, d, e, c, s);
        #1;
        rst_n     = 1'b1;
        digit_pos = '0;
        enter_pos = 1'b0;
        clear_pos = 1'b0;
        set_pos   = 1'b0;
        compare_all();
    endtask

    task automatic key(input int d);
        logic [9:0] one = 10'd1;
        tick(1, one << d, 0, 0, 0);
    endtask

    task automatic enter();
        tick(1, '0, 1, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1, '0, 0, 0, 0);
    endtask

    task automatic type_code(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) key(int'((code >> (4 * i)) & 16'hF));
    endtask

    task automatic all_zero(input string tag);
        check_eq({tag, "_outputs"},
                 {25'd0, unlocked, alarm, setting, entry_cnt == 3'd0, fail_cnt == 2'd0,
                  entry_buf == 16'd0, 1'b0}, 32'h0000_000E);
    endtask

    initial begin
        int pw_copy[$];
        int r;
        rst_n     = 1'b0;
        digit_pos = '0;
        enter_pos = 1'b0;
        clear_pos = 1'b0;
        set_pos   = 1'b0;
        model_reset();

        tick(0, '0, 0, 0, 0);
        tick(0, 10'h3FF, 1, 1, 1);
        all_zero("reset");

        // Correct entry, then automatic relock.
        type_code(16'h1234);
        check_eq("entry_1234", 32'(entry_buf), 32'h1234);
        enter();
        check_eq("unlock_ok", 32'(unlocked), 32'd1);
        check_eq("unlock_fail0", 32'(fail_cnt), 32'd0);
        idle(UNLOCK_CYCLES - 1);
        check_eq("still_open", 32'(unlocked), 32'd1);
        idle(1);
        check_eq("auto_relock", 32'(unlocked), 32'd0);

        // Failures to lockout.
        type_code(16'h1235);
        enter();
        check_eq("fail_1", 32'(fail_cnt), 32'd1);
        type_code(16'h1235);
        enter();
        check_eq("fail_2", 32'(fail_cnt), 32'd2);
        type_code(16'h1235);
        enter();
        check_eq("lockout_alarm", 32'(alarm), 32'd1);
        for (int i = 0; i < int'(LOCK_CYCLES) - 1; i++) key(i % 10);
        check_eq("lockout_hold", 32'(alarm), 32'd1);
        check_eq("lockout_nodigit", 32'(entry_cnt), 32'd0);
        idle(1);
        check_eq("lockout_exit", 32'(alarm), 32'd0);
        check_eq("lockout_fail0", 32'(fail_cnt), 32'd0);

        // Overflow, short entry, ambiguous digit.
        type_code(16'h1234);
        key(9);
        check_eq("overflow_buf", 32'(entry_buf), 32'h1234);
        check_eq("overflow_cnt", 32'(entry_cnt), 32'd4);
        tick(1, '0, 0, 1, 0);
        key(1);
        key(2);
        enter();
        check_eq("short_fail", 32'(fail_cnt), 32'd1);
        key(7);
        tick(1, 10'b00_0000_0011, 0, 0, 0);
        check_eq("ambiguous_cnt", 32'(entry_cnt), 32'd1);

        // Priority: clear beats enter and digit.
        tick(1, '0, 0, 1, 0);
        key(1);
        key(2);
        key(3);
        check_eq("prio_pre", 32'(entry_buf), 32'h0123);
        tick(1, 10'b00_0010_0000, 1, 1, 0);
        check_eq("prio_buf", 32'(entry_buf), 32'h0);
        check_eq("prio_fail", 32'(fail_cnt), 32'd1);
        check_eq("prio_locked", 32'(unlocked), 32'd0);

        // Password change, old code rejected, abort keeps password.
        type_code(16'h1234);
        enter();
        tick(1, '0, 0, 0, 1);
        check_eq("set_on", 32'(setting), 32'd1);
        type_code(16'h9876);
        enter();
        check_eq("set_done", 32'(setting), 32'd0);
        check_eq("set_locked", 32'(unlocked), 32'd0);
        type_code(16'h1234);
        enter();
        check_eq("old_rejected", 32'(fail_cnt), 32'd1);
        type_code(16'h9876);
        enter();
        check_eq("new_accepted", 32'(unlocked), 32'd1);
        tick(1, '0, 0, 0, 1);
        key(9);
        key(8);
        enter();
        check_eq("abort_open", 32'(unlocked), 32'd1);
        check_eq("abort_noset", 32'(setting), 32'd0);
        enter();
        check_eq("manual_relock", 32'(unlocked), 32'd0);
        type_code(16'h9876);
        enter();
        check_eq("pw_kept", 32'(unlocked), 32'd1);

        // Reset after a password change, then during lockout.
        tick(0, '0, 0, 0, 0);
        all_zero("reset_after_change");
        type_code(16'h1234);
        enter();
        check_eq("default_back", 32'(unlocked), 32'd1);
        enter();
        for (int k = 0; k < int'(MAX_FAIL); k++) begin
            key(0);
            enter();
        end
        check_eq("lockout_again", 32'(alarm), 32'd1);
        idle(5);
        tick(0, '0, 0, 0, 0);
        all_zero("reset_in_lockout");
        type_code(16'h1234);
        enter();
        check_eq("unlock_after_reset", 32'(unlocked), 32'd1);

        // Random traffic with occasional correct-code entry and rare resets.
        for (int n = 0; n < 4000; n++) begin
            r = int'($urandom_range(0, 999));
            if (r < 3) begin
                tick(0, '0, 0, 0, 0);
            end else if (r < 60 && !m_open && !m_alarm) begin
                pw_copy = m_pw;
                foreach (pw_copy[i]) key(pw_copy[i]);
                enter();
            end else if (r < 500) begin
                key(int'($urandom_range(0, 9)));
            end else if (r < 550) begin
                tick(1, 10'($urandom), 0, 0, 0);
            end else if (r < 650) begin
                enter();
            end else if (r < 700) begin
                tick(1, '0, 0, 1, 0);
            end else if (r < 760) begin
                tick(1, '0, 0, 0, 1);
            end else if (r < 800) begin
                tick(1, 10'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                idle(1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
